// File: rtl/reg_sequencer.sv
// Purpose : multi-cycle control stage in front of a 4x8 register file; fetches two
//           operands, runs a small ALU (ADD/SUB/XOR/LDI) and writes the result back.
// Latency : result is written into the register file 3 edges after acceptance.
//           Throughput is one instruction every 4 cycles.
// Backpres: IN_READY is high only in IDLE. Offered instructions wait until then.
//
// Ports:
//   CLK, RESET_N       clock, asynchronous active-low reset
//   IN_VALID/IN_READY  instruction handshake; IN_INSTR = {op[1:0], rd, rs1, rs2}
//   R1, R2 / RD1, RD2  register file read addresses / combinational read data
//   W, WD, RW          register file write address, data, enable
//   DONE               one-cycle pulse while the write is presented
//   ZERO, CARRY        flags of the last completed instruction
module reg_sequencer #(
   parameter int DATA_W = 8   // must be >= 4 so the LDI immediate fits
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              IN_VALID,
   input  logic [7:0]        IN_INSTR,
   output logic              IN_READY,
   output logic [1:0]        R1,
   output logic [1:0]        R2,
   input  logic [DATA_W-1:0] RD1,
   input  logic [DATA_W-1:0] RD2,
   output logic [1:0]        W,
   output logic [DATA_W-1:0] WD,
   output logic              RW,
   output logic              DONE,
   output logic              ZERO,
   output logic              CARRY
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_LDI = 2'b11;

   state_t            r_state;
   logic [7:0]        r_instr;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_result;
   logic              r_carry;       // carry of the instruction in flight
   logic              r_rw;
   logic              r_done;
   logic              r_zero_flag;
   logic              r_carry_flag;  // carry of the last completed instruction

   logic [1:0]        w_op;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_diff;
   logic [DATA_W-1:0] w_res;
   logic              w_carry_next;

   assign w_op = r_instr[7:6];

   // One extra bit on both paths: bit DATA_W of the sum is the carry-out,
   // bit DATA_W of the difference goes high exactly when A < B (borrow).
   assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff = {1'b0, r_a} - {1'b0, r_b};

   always_comb begin
      w_res        = '0;
      w_carry_next = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_res        = w_sum[DATA_W-1:0];
            w_carry_next = w_sum[DATA_W];
         end
         OP_SUB: begin
            w_res        = w_diff[DATA_W-1:0];
            w_carry_next = w_diff[DATA_W];
         end
         OP_XOR: begin
            w_res        = r_a ^ r_b;
            w_carry_next = 1'b0;
         end
         OP_LDI: begin
            // rs1/rs2 fields form a 4-bit immediate; operands are ignored
            w_res        = {{(DATA_W-4){1'b0}}, r_instr[3:0]};
            w_carry_next = 1'b0;
         end
         default: begin
            w_res        = '0;
            w_carry_next = 1'b0;
         end
      endcase
   end

   // Control FSM. RW/DONE are set on the EXEC->WRITE edge and cleared on the
   // WRITE->IDLE edge so they are high for exactly the WRITE cycle. Flags are
   // only touched when leaving WRITE, so an aborted instruction never updates them.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= ST_IDLE;
         r_instr      <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_result     <= '0;
         r_carry      <= 1'b0;
         r_rw         <= 1'b0;
         r_done       <= 1'b0;
         r_zero_flag  <= 1'b0;
         r_carry_flag <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (IN_VALID) begin
                  r_instr <= IN_INSTR;
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               r_a     <= RD1;
               r_b     <= RD2;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_result <= w_res;
               r_carry  <= w_carry_next;
               r_rw     <= 1'b1;
               r_done   <= 1'b1;
               r_state  <= ST_WRITE;
            end
            ST_WRITE: begin
               r_rw         <= 1'b0;
               r_done       <= 1'b0;
               r_zero_flag  <= (r_result == '0);
               r_carry_flag <= r_carry;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_rw    <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign IN_READY = (r_state == ST_IDLE);
   assign R1       = r_instr[3:2];
   assign R2       = r_instr[1:0];
   assign W        = r_instr[5:4];
   assign WD       = r_result;
   assign RW       = r_rw;
   assign DONE     = r_done;
   assign ZERO     = r_zero_flag;
   assign CARRY    = r_carry_flag;

endmodule
